// File: rtl/nmos_pmos_comparator_pkg.sv
// Shared types for the registered magnitude comparator: one-hot result struct and its constants.
package cmp_pkg;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_RESET = '0;
  localparam cmp_res_t CMP_RES_EQ    = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};

  function automatic logic is_one_hot(input cmp_res_t r);
    return (r == 3'b100) || (r == 3'b010) || (r == 3'b001);
  endfunction

endpackage

// File: rtl/nmos_pmos_comparator_if.sv
// Operand/result bundle for nmos_pmos_comparator. Cascade inputs exist only when
// CMP_CASCADE_EN is defined.
interface nmos_pmos_comparator_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
`ifdef CMP_CASCADE_EN
  logic             casc_eq_i;
  logic             casc_lt_i;
  logic             casc_gt_i;
`endif
  logic             out_valid;
  logic             aeb_o;
  logic             ailb_o;
  logic             asgb_o;

`ifdef CMP_CASCADE_EN
  modport master (output in_valid, a_i, b_i, casc_eq_i, casc_lt_i, casc_gt_i,
                  input  out_valid, aeb_o, ailb_o, asgb_o);
  modport slave  (input  in_valid, a_i, b_i, casc_eq_i, casc_lt_i, casc_gt_i,
                  output out_valid, aeb_o, ailb_o, asgb_o);
`else
  modport master (output in_valid, a_i, b_i,
                  input  out_valid, aeb_o, ailb_o, asgb_o);
  modport slave  (input  in_valid, a_i, b_i,
                  output out_valid, aeb_o, ailb_o, asgb_o);
`endif
endinterface

// File: rtl/nmos_pmos_comparator_bit_slice.sv
// Per-bit greater/less/equal generator, the logic equivalent of one column of the transistor cell.
module cmp_bit_slice (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);
  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(gt | lt);
endmodule

// File: rtl/nmos_pmos_comparator.sv
// Registered unsigned magnitude comparator with one-hot eq/lt/gt flags and 1-cycle latency.
// Optional 7485-style cascade inputs are enabled by defining CMP_CASCADE_EN.
module nmos_pmos_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  nmos_pmos_comparator_if.slave bus
);

  logic [WIDTH-1:0] gt_s;
  logic [WIDTH-1:0] lt_s;
  logic [WIDTH-1:0] eq_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    cmp_bit_slice u_slice (
      .a  (bus.a_i[i]),
      .b  (bus.b_i[i]),
      .gt (gt_s[i]),
      .lt (lt_s[i]),
      .eq (eq_s[i])
    );
  end

  // Stage p0: MSB-first priority chain and cascade merge
  logic     run_eq;
  logic     gt_any;
  logic     lt_any;
  logic     all_eq;
  cmp_res_t res_p0;

  always_comb begin
    run_eq = 1'b1;
    gt_any = 1'b0;
    lt_any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gt_any = gt_any | (gt_s[i] & run_eq);
      lt_any = lt_any | (lt_s[i] & run_eq);
      run_eq = run_eq & eq_s[i];
    end
    all_eq = run_eq;
  end

`ifdef CMP_CASCADE_EN
  cmp_res_t casc;
  assign casc = '{eq: bus.casc_eq_i, lt: bus.casc_lt_i, gt: bus.casc_gt_i};
`endif

  always_comb begin
    res_p0 = CMP_RES_EQ;
    if (!all_eq) begin
      res_p0 = '{eq: 1'b0, lt: lt_any, gt: gt_any};
    end
`ifdef CMP_CASCADE_EN
    // Malformed cascade codes fall back to "equal" so the output stays one-hot.
    else if (is_one_hot(casc)) begin
      res_p0 = casc;
    end
`endif
  end

  // Stage p1: result and valid registers
  cmp_res_t res_p1;
  logic     vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= CMP_RES_RESET;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        res_p1 <= res_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.aeb_o     = res_p1.eq;
  assign bus.ailb_o    = res_p1.lt;
  assign bus.asgb_o    = res_p1.gt;

endmodule

// File: tb/tb_nmos_pmos_comparator.sv
// Scoreboard bench for nmos_pmos_comparator (WIDTH = 4); cascade cases run when CMP_CASCADE_EN is defined.
module tb_nmos_pmos_comparator;
  import cmp_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nmos_pmos_comparator_if #(.WIDTH(WIDTH)) bus ();

  nmos_pmos_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int       errors = 0;
  int       checks = 0;
  cmp_res_t sb_q[$];
  cmp_res_t held;
  cmp_res_t casc_drv;

  localparam cmp_res_t R_EQ = 3'b100;
  localparam cmp_res_t R_LT = 3'b010;
  localparam cmp_res_t R_GT = 3'b001;

  function automatic cmp_res_t model(input int a, input int b);
    if (a > b) return R_GT;
    if (a < b) return R_LT;
`ifdef CMP_CASCADE_EN
    if (casc_drv == R_EQ || casc_drv == R_LT || casc_drv == R_GT) return casc_drv;
`endif
    return R_EQ;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input cmp_res_t exp);
    logic [2:0] obs;
    obs = {bus.aeb_o, bus.ailb_o, bus.asgb_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed eq/lt/gt=%b expected=%b (a=%0d b=%0d)", tag, obs, exp,
             bus.a_i, bus.b_i);
    end
  endtask

  task automatic observe(input logic v);
    cmp_res_t exp;
    check_bit("out_valid", bus.out_valid, v);
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_bit("sb_underflow", 1'b1, 1'b0);
      end else begin
        exp = sb_q.pop_front();
        check_res("result", exp);
        check_bit("onehot", is_one_hot({bus.aeb_o, bus.ailb_o, bus.asgb_o}), 1'b1);
        held = exp;
      end
    end else begin
      check_res("hold", held);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.in_valid = v;
    bus.a_i      = a;
    bus.b_i      = b;
`ifdef CMP_CASCADE_EN
    bus.casc_eq_i = casc_drv.eq;
    bus.casc_lt_i = casc_drv.lt;
    bus.casc_gt_i = casc_drv.gt;
`endif
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    drive(v, a, b);
    if (v) sb_q.push_back(model(int'(a), int'(b)));
    @(posedge clk);
    #1;
    observe(v);
  endtask

  task automatic step_x(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input cmp_res_t exp);
    drive(1'b1, a, b);
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    observe(1'b1);
  endtask

  initial begin
    casc_drv = R_EQ;
    held     = CMP_RES_RESET;
    rst_n    = 1'b0;
    drive(1'b0, '0, '0);
    #2;
    check_bit("reset_vld", bus.out_valid, 1'b0);
    check_res("reset_flags", CMP_RES_RESET);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b0, 4'h3, 4'h4);

    step_x(4'hA, 4'hA, R_EQ);
    step_x(4'b1000, 4'b0111, R_GT);
    step_x(4'b0111, 4'b1000, R_LT);
    step_x(4'b0110, 4'b0111, R_LT);
    step_x(4'b0001, 4'b0000, R_GT);
    step(1'b0, 4'hF, 4'h0);

    // Asynchronous reset with a new sample pending on the inputs
    step_x(4'hC, 4'h2, R_GT);
    drive(1'b1, 4'h1, 4'h9);
    #1 rst_n = 1'b0;
    #1;
    check_bit("async_rst_vld", bus.out_valid, 1'b0);
    check_res("async_rst_flags", CMP_RES_RESET);
    held = CMP_RES_RESET;
    @(posedge clk);
    #1;
    check_res("rst_held_flags", CMP_RES_RESET);
    check_bit("rst_held_vld", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    step_x(4'h3, 4'h9, R_LT);
    step(1'b0, 4'h9, 4'h3);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(1'b1, 4'(a), 4'(b));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        step(1'b1, 4'(a), 4'(b));
        if ($urandom_range(0, 1) == 1) step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    step(1'b0, 4'h0, 4'hF);

`ifdef CMP_CASCADE_EN
    casc_drv = R_LT;
    step_x(4'h5, 4'h5, R_LT);
    casc_drv = R_GT;
    step_x(4'h5, 4'h5, R_GT);
    casc_drv = 3'b000;
    step_x(4'h5, 4'h5, R_EQ);
    casc_drv = 3'b011;
    step_x(4'h5, 4'h5, R_EQ);
    casc_drv = R_LT;
    step_x(4'h6, 4'h5, R_GT);
    casc_drv = R_GT;
    step_x(4'h4, 4'h5, R_LT);
    casc_drv = R_EQ;
`endif

    check_bit("sb_drain", sb_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
